// File: rtl/fsm_cmp_sequencer.sv
// Serializes parallel words LSB-first onto the shared sequence-detector input and
// cross-checks the Moore, Mealy and gate-level detector outputs on every bit.
module fsm_cmp_sequencer #(
   parameter int WIDTH = 14,
   parameter int CNT_W = 5,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             word_valid,
   input  logic [WIDTH-1:0] word_data,
   output logic             word_ready,
   output logic             ser_in,
   input  logic             det_moore,
   input  logic             det_mealy,
   input  logic             det_gate,
   input  logic             stat_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] det_count,
   output logic             word_err,
   output logic [ERR_W-1:0] err_count
);

   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [IDX_W-1:0] bit_idx_q;
   logic             ser_in_q;
   logic             word_ready_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] det_count_q;
   logic             word_err_q;
   logic [ERR_W-1:0] err_count_q;

   logic             accept;
   logic             mismatch;
   logic             last_bit;
   logic [CNT_W-1:0] det_count_d;
   logic             word_err_d;
   logic [ERR_W-1:0] err_count_d;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   // word_ready_q is only high in IDLE/DONE, so it alone qualifies an accept
   assign accept   = word_valid && word_ready_q;
   assign mismatch = (det_moore ^ det_mealy) | (det_moore ^ det_gate) | (det_mealy ^ det_gate);
   assign last_bit = (bit_idx_q == LAST_IDX);

   assign det_count_d = det_moore ? sat_inc_cnt(det_count_q) : det_count_q;
   assign word_err_d  = word_err_q | mismatch;

   always_comb begin
      err_count_d = err_count_q;
      if (stat_clr) begin
         err_count_d = '0;
      end else if ((state_q == SHIFT) && mismatch) begin
         err_count_d = sat_inc_err(err_count_q);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_idx_q    <= '0;
         ser_in_q     <= 1'b0;
         word_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         det_count_q  <= '0;
         word_err_q   <= 1'b0;
         err_count_q  <= '0;
      end else begin
         done_q      <= 1'b0;
         err_count_q <= err_count_d;
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  state_q      <= SHIFT;
                  shreg_q      <= word_data;
                  bit_idx_q    <= '0;
                  ser_in_q     <= word_data[0];
                  word_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                  det_count_q  <= '0;
                  word_err_q   <= 1'b0;
               end else begin
                  state_q      <= IDLE;
                  ser_in_q     <= 1'b0;
                  word_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            SHIFT: begin
               // Detector outputs for bit k are sampled at the edge that ends cycle k
               det_count_q <= det_count_d;
               word_err_q  <= word_err_d;
               shreg_q     <= shreg_q >> 1;
               bit_idx_q   <= bit_idx_q + IDX_W'(1);
               if (last_bit) begin
                  state_q      <= DONE;
                  ser_in_q     <= 1'b0;
                  word_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end else begin
                  ser_in_q <= shreg_q[1];
               end
            end
            default: begin
               state_q      <= IDLE;
               ser_in_q     <= 1'b0;
               word_ready_q <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign word_ready = word_ready_q;
   assign ser_in     = ser_in_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign det_count  = det_count_q;
   assign word_err   = word_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_fsm_cmp_sequencer.sv
// Scoreboard bench for fsm_cmp_sequencer: directed words with hand-computed results,
// a monitor checks every serialized bit and every done pulse.
module tb_fsm_cmp_sequencer;

   localparam int WIDTH = 14;
   localparam int CNT_W = 5;
   localparam int ERR_W = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b1;
   logic             word_valid = 1'b0;
   logic [WIDTH-1:0] word_data = '0;
   logic             word_ready;
   logic             ser_in;
   logic             det_moore, det_mealy, det_gate;
   logic             stat_clr;
   logic             busy, done;
   logic [CNT_W-1:0] det_count;
   logic             word_err;
   logic [ERR_W-1:0] err_count;

   logic [WIDTH-1:0] gate_mask = '0;
   logic             clr_last = 1'b0;
   logic             clr_req = 1'b0;
   logic [4:0]       k;
   int               cyc = 0;
   int               n_tests = 0;
   int               n_fail = 0;

   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic             err;
      logic [ERR_W-1:0] ecnt;
      int               cyc;
   } exp_t;

   exp_t sb_q[$];
   logic ser_q[$];
   exp_t e_mon;
   logic b_mon;

   fsm_cmp_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rstn(rstn), .word_valid(word_valid), .word_data(word_data),
      .word_ready(word_ready), .ser_in(ser_in), .det_moore(det_moore),
      .det_mealy(det_mealy), .det_gate(det_gate), .stat_clr(stat_clr),
      .busy(busy), .done(done), .det_count(det_count), .word_err(word_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SHIFT-cycle index, used to place forced detector mismatches
   always @(posedge clk or negedge rstn) begin
      if (!rstn) k <= '0;
      else if (busy) k <= k + 5'd1;
      else k <= '0;
   end

   assign det_moore = ser_in;
   assign det_mealy = ser_in;
   assign det_gate  = ser_in ^ (busy && (k < WIDTH) && gate_mask[k[3:0]]);
   assign stat_clr  = clr_req | (clr_last && busy && (k == 5'(WIDTH - 1)));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event, expected none", nm);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (busy) begin
            chk("ready_in_shift", 32'(word_ready), 32'd0);
            if (ser_q.size() == 0) flag("ser_unexpected");
            else begin
               b_mon = ser_q.pop_front();
               chk("ser_bit", 32'(ser_in), 32'(b_mon));
            end
         end
         if (done) begin
            chk("done_ser_in", 32'(ser_in), 32'd0);
            chk("done_ready", 32'(word_ready), 32'd1);
            if (sb_q.size() == 0) flag("done_unexpected");
            else begin
               e_mon = sb_q.pop_front();
               chk("det_count", 32'(det_count), 32'(e_mon.cnt));
               chk("word_err", 32'(word_err), 32'(e_mon.err));
               chk("err_count", 32'(err_count), 32'(e_mon.ecnt));
               chk("done_cycle", 32'(cyc), 32'(e_mon.cyc));
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] gm, input logic cl,
                       input logic hold, input logic [CNT_W-1:0] ec, input logic ew,
                       input logic [ERR_W-1:0] ee, output int acc);
      int g;
      exp_t e;
      g = 0;
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = d;
      while (!word_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!word_ready) begin
         flag("accept_timeout");
         acc = -1;
         word_valid = 1'b0;
         return;
      end
      acc   = cyc;
      e.cnt = ec; e.err = ew; e.ecnt = ee; e.cyc = cyc + WIDTH + 1;
      sb_q.push_back(e);
      for (int i = 0; i < WIDTH; i++) ser_q.push_back(d[i]);
      @(posedge clk);
      #1;
      gate_mask = gm;
      clr_last  = cl;
      if (!hold) word_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (sb_q.size() != 0) flag("drain_timeout");
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ser_in"}, 32'(ser_in), 32'd0);
      chk({tag, "_word_ready"}, 32'(word_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_det_count"}, 32'(det_count), 32'd0);
      chk({tag, "_word_err"}, 32'(word_err), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, a1, a2;
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rstn = 1'b1;

      // 7 = bits 0..2 set, detectors agree
      send(14'd7, 14'h0000, 1'b0, 1'b0, 5'd3, 1'b0, 2'd0, a0);
      drain();

      // gate detector disagrees in SHIFT cycles 4 and 9
      send(14'd0, 14'h0210, 1'b0, 1'b0, 5'd0, 1'b1, 2'd2, a0);
      drain();

      // permanent mismatch: 2 + 14 saturates a 2-bit counter
      send(14'd0, 14'h3FFF, 1'b0, 1'b0, 5'd0, 1'b1, 2'd3, a0);
      drain();

      // clear coincides with a mismatch on the last bit; det_count/word_err unaffected
      send(14'd5, 14'h3FFF, 1'b1, 1'b0, 5'd2, 1'b1, 2'd0, a0);
      drain();
      clr_last = 1'b0;

      // back-to-back with word_valid held high
      send(14'd0,  14'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 2'd0, a0);
      send(14'd7,  14'h0000, 1'b0, 1'b1, 5'd3, 1'b0, 2'd0, a1);
      send(14'd14, 14'h0000, 1'b0, 1'b0, 5'd3, 1'b0, 2'd0, a2);
      chk("b2b_gap1", 32'(a1 - a0), 32'd15);
      chk("b2b_gap2", 32'(a2 - a1), 32'd15);
      drain();

      // data changes while shifting must not disturb the captured word
      send(14'h2A5B, 14'h0000, 1'b0, 1'b1, 5'd8, 1'b0, 2'd0, a0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         word_data = word_data ^ 14'(i * 14'h1357);
      end
      word_valid = 1'b0;
      drain();

      // reset mid-word: build up state, then abandon the word
      send(14'h3FFF, 14'h3FFF, 1'b0, 1'b0, 5'd14, 1'b1, 2'd3, a0);
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk_reset_vals("midrst");
      sb_q.delete();
      ser_q.delete();
      gate_mask = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("post_rst_ready", 32'(word_ready), 32'd1);
      repeat (20) @(negedge clk);

      send(14'd7, 14'h0000, 1'b0, 1'b0, 5'd3, 1'b0, 2'd0, a0);
      drain();
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("final_ser_empty", 32'(ser_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
